// File: rtl/rr_onehot_grant_sched_pkg.sv
// ----------------------------------------------------------------------------
// sched_pkg
//   Shared types and helpers for the round-robin grant scheduler family.
//   - sched_state_e : scheduler FSM states (IDLE, GRANT, GAP)
//   - clog2         : ceiling log2, usable in constant expressions
//   - DEF_*         : default parameter values for the scheduler top
//   - RST_PTR       : last-winner pointer value after reset for the default
//                     configuration (N_REQ-1, so the first search starts at 0)
// ----------------------------------------------------------------------------
package sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } sched_state_e;

    localparam int DEF_N_REQ    = 15;
    localparam int DEF_IDX_W    = 4;
    localparam int DEF_MAX_HOLD = 8;
    localparam int RST_PTR      = DEF_N_REQ - 1;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_onehot_grant_sched_next_idx.sv
// ----------------------------------------------------------------------------
// rr_next_idx
//   Combinational round-robin search. Returns the first set request bit
//   strictly after last_ptr, wrapping from N_REQ-1 back to 0.
//   Ports:
//     req      in   N_REQ  request vector
//     last_ptr in   IDX_W  index of the previous winner
//     any      out  1      at least one request is set
//     idx      out  IDX_W  winning index (meaningful only when any=1)
// ----------------------------------------------------------------------------
module rr_next_idx #(
    parameter int N_REQ = 15,
    parameter int IDX_W = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_ptr,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [IDX_W:0]     start;
    logic [IDX_W:0]     off;
    logic [IDX_W:0]     sum;

    always_comb begin
        // Search begins one past the previous winner; N_REQ-1 wraps to 0.
        if (last_ptr >= IDX_W'(N_REQ - 1)) begin
            start = '0;
        end else begin
            start = {1'b0, last_ptr} + 1'b1;
        end

        // Doubling the vector turns the rotate into a plain right shift:
        // bit k of rot is request (start + k) mod N_REQ.
        dbl = {req, req};
        rot = N_REQ'(dbl >> start);

        // Lowest set bit of the rotated vector is the winner's offset.
        off = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) off = (IDX_W + 1)'(i);
        end

        sum = start + off;
        if (sum >= (IDX_W + 1)'(N_REQ)) begin
            sum = sum - (IDX_W + 1)'(N_REQ);
        end

        any = |req;
        idx = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/rr_onehot_grant_sched.sv
// ----------------------------------------------------------------------------
// rr_onehot_grant_sched
//   Round-robin scheduler sharing one binary-indexed select bus among up to
//   N_REQ requesters. A winner holds the grant until it releases, drops its
//   request, or has held for MAX_HOLD cycles; every grant is followed by one
//   bubble cycle (GAP) with grant_valid low so the downstream select settles.
//   All outputs are registered.
//   Ports:
//     clk          in   1      rising-edge clock
//     rst          in   1      asynchronous active-high reset
//     req          in   N_REQ  level-sensitive requests, bit i = requester i
//     release_i    in   1      current owner done (looked at only in GRANT)
//     grant_valid  out  1      grant active (bin->onehot decoder in_valid)
//     grant_idx    out  IDX_W  owner index (decoder in); holds while invalid
//     grant_onehot out  N_REQ  registered one-hot of grant_idx, 0 when invalid
//     busy         out  1      scheduler not IDLE
//     timeout      out  1      one-cycle pulse: grant ended on the hold limit
// ----------------------------------------------------------------------------
module rr_onehot_grant_sched
    import sched_pkg::*;
#(
    parameter int N_REQ    = DEF_N_REQ,
    parameter int IDX_W    = DEF_IDX_W,
    parameter int MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             release_i,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N_REQ-1:0] grant_onehot,
    output logic             busy,
    output logic             timeout
);

    localparam int               CNT_W     = clog2(MAX_HOLD) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [IDX_W-1:0] PTR_RST   = IDX_W'(N_REQ - 1);

    sched_state_e     state_q, state_d;
    logic [IDX_W-1:0] last_ptr_q, last_ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             grant_valid_q, grant_valid_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [N_REQ-1:0] grant_onehot_q, grant_onehot_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;

    logic             nxt_any;
    logic [IDX_W-1:0] nxt_idx;
    logic             owner_req;
    logic             hold_done;

    function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            oh[i] = (idx == IDX_W'(i));
        end
        return oh;
    endfunction

    rr_next_idx #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_next_idx (
        .req      (req),
        .last_ptr (last_ptr_q),
        .any      (nxt_any),
        .idx      (nxt_idx)
    );

    always_comb begin
        state_d        = state_q;
        last_ptr_d     = last_ptr_q;
        hold_cnt_d     = hold_cnt_q;
        grant_valid_d  = grant_valid_q;
        grant_idx_d    = grant_idx_q;
        grant_onehot_d = grant_onehot_q;
        timeout_d      = 1'b0;

        owner_req = req[grant_idx_q];
        hold_done = (hold_cnt_q == HOLD_LAST);

        case (state_q)
            GRANT: begin
                if (release_i || !owner_req || hold_done) begin
                    state_d        = GAP;
                    grant_valid_d  = 1'b0;
                    grant_onehot_d = '0;
                    // Release and request drop take precedence over the limit.
                    timeout_d      = hold_done && !release_i && owner_req;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE and GAP both arbitrate; GAP lasts exactly one cycle.
                if (nxt_any) begin
                    state_d        = GRANT;
                    last_ptr_d     = nxt_idx;
                    hold_cnt_d     = '0;
                    grant_valid_d  = 1'b1;
                    grant_idx_d    = nxt_idx;
                    grant_onehot_d = to_onehot(nxt_idx);
                end else begin
                    state_d = IDLE;
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            last_ptr_q     <= PTR_RST;
            hold_cnt_q     <= '0;
            grant_valid_q  <= 1'b0;
            grant_idx_q    <= '0;
            grant_onehot_q <= '0;
            busy_q         <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            last_ptr_q     <= last_ptr_d;
            hold_cnt_q     <= hold_cnt_d;
            grant_valid_q  <= grant_valid_d;
            grant_idx_q    <= grant_idx_d;
            grant_onehot_q <= grant_onehot_d;
            busy_q         <= busy_d;
            timeout_q      <= timeout_d;
        end
    end

    assign grant_valid  = grant_valid_q;
    assign grant_idx    = grant_idx_q;
    assign grant_onehot = grant_onehot_q;
    assign busy         = busy_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_rr_onehot_grant_sched.sv
// ----------------------------------------------------------------------------
// tb_rr_onehot_grant_sched
//   Directed scenarios with literal expectations followed by randomized
//   request/release traffic, all compared every cycle against a behavioural
//   model of the scheduler (owner / bubble / last-winner bookkeeping).
// ----------------------------------------------------------------------------
module tb_rr_onehot_grant_sched;

    localparam int N        = 15;
    localparam int IW       = 4;
    localparam int MAX_HOLD = 8;
    // A requester whose own grant just ended also waits out its own bubble.
    localparam int STARVE_BOUND = (N - 1) * (MAX_HOLD + 1) + 1;

    logic          clk;
    logic          rst;
    logic [N-1:0]  req;
    logic          rel;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic [N-1:0]  grant_onehot;
    logic          busy;
    logic          timeout;

    int checks;
    int failures;

    rr_onehot_grant_sched #(
        .N_REQ    (N),
        .IDX_W    (IW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .release_i    (rel),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .busy         (busy),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_owner;   // current owner, -1 when nobody holds the bus
    int m_held;    // grant cycles completed by the current owner
    int m_last;    // previous winner
    int m_idx;     // last index shown on the bus
    bit m_gap;     // in the bubble after a grant
    bit m_to;      // timeout pulse

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            int c;
            c = (last + k) % N;
            if (r[4'(c)]) return c;
        end
        return -1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = -1;
            m_held  = 0;
            m_last  = N - 1;
            m_idx   = 0;
            m_gap   = 1'b0;
            m_to    = 1'b0;
        end else begin
            int w;
            m_to = 1'b0;
            if (m_owner >= 0) begin
                if (rel || !req[4'(m_owner)] || (m_held + 1 >= MAX_HOLD)) begin
                    m_to    = !rel && req[4'(m_owner)];
                    m_owner = -1;
                    m_gap   = 1'b1;
                end else begin
                    m_held++;
                end
            end else begin
                m_gap = 1'b0;
                w = pick(req, m_last);
                if (w >= 0) begin
                    m_owner = w;
                    m_held  = 0;
                    m_last  = w;
                    m_idx   = w;
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int waitc [N];

    always @(negedge clk) begin
        logic [N-1:0] exp_oh;
        int           max_wait;
        exp_oh = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
        chk("cmp_valid",   32'(grant_valid),  32'(m_owner >= 0));
        chk("cmp_idx",     32'(grant_idx),    32'(m_idx));
        chk("cmp_onehot",  32'(grant_onehot), 32'(exp_oh));
        chk("cmp_busy",    32'(busy),         32'((m_owner >= 0) || m_gap));
        chk("cmp_timeout", 32'(timeout),      32'(m_to));
        chk("onehot_vs_idx", 32'(grant_onehot),
            grant_valid ? (32'd1 << grant_idx) : 32'd0);
        chk("onehot_bits_le1", 32'($countones(grant_onehot) <= 1), 32'd1);

        max_wait = 0;
        for (int i = 0; i < N; i++) begin
            if (rst || !req[4'(i)] || (grant_valid && (32'(grant_idx) == i))) begin
                waitc[i] = 0;
            end else begin
                waitc[i] = waitc[i] + 1;
            end
            if (waitc[i] > max_wait) max_wait = waitc[i];
        end
        chk("starve_bound", 32'(max_wait > STARVE_BOUND), 32'd0);
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < N; i++) waitc[i] = 0;
        rst = 1'b1;
        req = '0;
        rel = 1'b0;
        tick();
        tick();
        chk("rst_valid",  32'(grant_valid),  32'd0);
        chk("rst_onehot", 32'(grant_onehot), 32'd0);
        chk("rst_busy",   32'(busy),         32'd0);
        rst = 1'b0;
        tick();

        // Two requesters from IDLE, release three cycles into the grant.
        req = 15'h0005;
        tick();
        chk("t2_idx0",    32'(grant_idx),    32'd0);
        chk("t2_oh0",     32'(grant_onehot), 32'h0001);
        chk("t2_valid0",  32'(grant_valid),  32'd1);
        tick();
        tick();
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("t2_gap_valid", 32'(grant_valid), 32'd0);
        chk("t2_gap_busy",  32'(busy),        32'd1);
        chk("t2_gap_to",    32'(timeout),     32'd0);
        tick();
        chk("t2_idx2",    32'(grant_idx),    32'd2);
        chk("t2_oh2",     32'(grant_onehot), 32'h0004);

        // Move ownership to 14, then check the wrap from last_ptr=14.
        req = 15'h4000;
        tick();
        tick();
        chk("t3_idx14a", 32'(grant_idx), 32'd14);
        req = 15'h4002;
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        chk("t3_wrap_idx1", 32'(grant_idx),    32'd1);
        chk("t3_wrap_oh1",  32'(grant_onehot), 32'h0002);
        rel = 1'b1;
        tick();
        rel = 1'b0;
        tick();
        chk("t3_idx14b", 32'(grant_idx),    32'd14);
        chk("t3_oh14b",  32'(grant_onehot), 32'h4000);

        // Hold timeout on a lone requester 3.
        req = 15'h0008;
        tick();
        tick();
        for (int k = 0; k < MAX_HOLD; k++) begin
            chk("t4_hold_valid", 32'(grant_valid), 32'd1);
            chk("t4_hold_idx",   32'(grant_idx),   32'd3);
            tick();
        end
        chk("t4_timeout",     32'(timeout),     32'd1);
        chk("t4_gap_valid",   32'(grant_valid), 32'd0);
        tick();
        chk("t4_to_cleared",  32'(timeout),     32'd0);
        chk("t4_regrant_idx", 32'(grant_idx),   32'd3);
        chk("t4_regrant_vld", 32'(grant_valid), 32'd1);

        // Owner 5 drops its request and releases together: no timeout.
        req = 15'h0020;
        tick();
        tick();
        chk("t5_idx5", 32'(grant_idx), 32'd5);
        req = '0;
        rel = 1'b1;
        tick();
        rel = 1'b0;
        chk("t5_gap_valid", 32'(grant_valid), 32'd0);
        chk("t5_gap_to",    32'(timeout),     32'd0);
        chk("t5_gap_busy",  32'(busy),        32'd1);
        tick();
        chk("t5_idle_busy", 32'(busy), 32'd0);

        // Asynchronous reset in the middle of a grant.
        req = 15'h7FFF;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("t1_async_valid",  32'(grant_valid),  32'd0);
        chk("t1_async_onehot", 32'(grant_onehot), 32'd0);
        chk("t1_async_idx",    32'(grant_idx),    32'd0);
        chk("t1_async_busy",   32'(busy),         32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t1_first_idx", 32'(grant_idx),    32'd0);
        chk("t1_first_oh",  32'(grant_onehot), 32'h0001);

        // Randomized traffic in four flavours.
        for (int c = 0; c < 10000; c++) begin
            int phase;
            phase = c / 2500;
            if ($urandom_range(0, 5) == 0) begin
                case (phase)
                    0:       req = N'($urandom);
                    1:       req = N'($urandom & $urandom);
                    2:       req = 15'h7FFF;
                    default: req = N'($urandom) | 15'h0100;
                endcase
            end
            if (phase == 2) rel = ($urandom_range(0, 15) == 0);
            else            rel = ($urandom_range(0, 5) == 0);
            tick();
        end
        rel = 1'b0;
        req = '0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
